soc_uart: RTL and testbench

- Memory-mapped 8N1 UART slave on the CPU external bus (addr/rw/din/dout/valid/ready), sitting beside the BRAM controller downstream of the CPU.
- Drives the board TX pin and samples the RX pin.
- Holds a TX FIFO and an RX FIFO so the CPU can move bytes without per-bit polling.
- A top-level address decoder steers valid to this block and muxes dread back; decode is outside this block.

---
 rtl/soc_uart.sv | 340 ++++++++++++++++++++++++++++++++++
 tb/tb_soc_uart.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_uart.sv
// soc_uart: memory-mapped 8N1 UART slave with TX and RX FIFOs on the CPU external bus.
// Latency: bus reply (ready, dread) one cycle after valid; serial bit period DIV+1 clocks.
// Backpressure: bus never stalls; full TX FIFO drops writes (tx_ovf), full RX FIFO drops bytes (rx_ovr).

module soc_uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_dat,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_drop
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_pop_ok;
  logic             w_push_ok;

  // Wrap bit distinguishes full from empty when the index bits match.
  assign o_empty    = (r_wr_ptr == r_rd_ptr);
  assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop_ok   = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_push_ok  = i_push && (!o_full || w_pop_ok);
  assign o_drop     = i_push && !w_push_ok;
  assign o_head_dat = r_mem[r_rd_ptr[AW-1:0]];

  // Storage array, no reset needed: contents are only visible through the pointers.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
  end

  // Pointer update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end
endmodule

module soc_uart #(
  parameter int DEFAULT_DIV = 103,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  addr,
  input  logic        rw,
  input  logic [31:0] dwrite,
  output logic [31:0] dread,
  input  logic        valid,
  output logic        ready,
  input  logic        rx,
  output logic        tx
);
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

  // Bus and register state
  logic [31:0] r_dread;
  logic        r_ready;
  logic [15:0] r_div;
  logic        r_rx_ovr;
  logic        r_frame_err;
  logic        r_tx_ovf;

  // TX state
  tx_state_t   r_tx_state;
  logic        r_tx;
  logic [15:0] r_tx_cnt;
  logic [15:0] r_tx_div;
  logic [7:0]  r_tx_shift;
  logic [2:0]  r_tx_bit;

  // RX state
  rx_state_t   r_rx_state;
  logic        r_rx_s1;
  logic        r_rx_s2;
  logic        r_rx_s3;
  logic [15:0] r_rx_cnt;
  logic [15:0] r_rx_div;
  logic [7:0]  r_rx_shift;
  logic [2:0]  r_rx_bit;

  logic [1:0]  w_sel;
  logic        w_wr;
  logic        w_rd;
  logic        w_tx_push;
  logic        w_tx_pop;
  logic [7:0]  w_tx_head;
  logic        w_tx_empty;
  logic        w_tx_full;
  logic        w_tx_drop;
  logic        w_tx_busy;
  logic        w_rx_push;
  logic        w_rx_pop;
  logic [7:0]  w_rx_head;
  logic        w_rx_empty;
  logic        w_rx_full;
  logic        w_rx_drop;
  logic        w_rx_fall;
  logic        w_frame_err_set;
  logic [2:0]  w_clr;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign dread = r_dread;
  assign ready = r_ready;
  assign tx    = r_tx;

  assign w_sel     = addr[3:2];
  assign w_wr      = valid && rw;
  assign w_rd      = valid && !rw;
  assign w_tx_push = w_wr && (w_sel == 2'd0);
  assign w_rx_pop  = w_rd && (w_sel == 2'd0);
  assign w_clr     = (w_wr && (w_sel == 2'd1)) ? dwrite[6:4] : 3'b000;
  assign w_tx_busy = (r_tx_state != TX_IDLE);
  assign w_unused  = ^{addr[1:0], dwrite[31:16]};

  // The shifter takes the next byte on leaving IDLE and at the end of a stop bit.
  assign w_tx_pop = ((r_tx_state == TX_IDLE) && !w_tx_empty) ||
                    ((r_tx_state == TX_STOP) && (r_tx_cnt == 16'd0) && !w_tx_empty);

  assign w_rx_fall       = r_rx_s3 && !r_rx_s2;
  assign w_rx_push       = (r_rx_state == RX_STOP) && (r_rx_cnt == 16'd0) && r_rx_s2;
  assign w_frame_err_set = (r_rx_state == RX_STOP) && (r_rx_cnt == 16'd0) && !r_rx_s2;

  soc_uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_push     (w_tx_push),
    .i_push_dat (dwrite[7:0]),
    .i_pop      (w_tx_pop),
    .o_head_dat (w_tx_head),
    .o_empty    (w_tx_empty),
    .o_full     (w_tx_full),
    .o_drop     (w_tx_drop)
  );

  soc_uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_push     (w_rx_push),
    .i_push_dat (r_rx_shift),
    .i_pop      (w_rx_pop),
    .o_head_dat (w_rx_head),
    .o_empty    (w_rx_empty),
    .o_full     (w_rx_full),
    .o_drop     (w_rx_drop)
  );

  // Read mux; an empty RX FIFO reads as all zeros rather than stale storage.
  always_comb begin
    w_rdata = 32'd0;
    case (w_sel)
      2'd0: w_rdata = w_rx_empty ? 32'd0 : {23'd0, 1'b1, w_rx_head};
      2'd1: w_rdata = {24'd0, w_tx_busy, r_tx_ovf, r_frame_err, r_rx_ovr,
                       w_rx_full, w_rx_empty, w_tx_empty, w_tx_full};
      2'd2: w_rdata = {16'd0, r_div};
      default: w_rdata = 32'd0;
    endcase
  end

  // One-cycle completion strobe with registered read data, zero when idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ready <= 1'b0;
      r_dread <= 32'd0;
    end else begin
      r_ready <= valid;
      r_dread <= w_rd ? w_rdata : 32'd0;
    end
  end

  // Baud divisor; tiny values are clamped so each bit still spans several clocks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div <= 16'(DEFAULT_DIV);
    end else if (w_wr && (w_sel == 2'd2)) begin
      r_div <= (dwrite[15:0] < 16'd3) ? 16'd3 : dwrite[15:0];
    end
  end

  // Sticky error flags: a new event in the same cycle as a W1C clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_ovr    <= 1'b0;
      r_frame_err <= 1'b0;
      r_tx_ovf    <= 1'b0;
    end else begin
      r_rx_ovr    <= (r_rx_ovr    & ~w_clr[0]) | w_rx_drop;
      r_frame_err <= (r_frame_err & ~w_clr[1]) | w_frame_err_set;
      r_tx_ovf    <= (r_tx_ovf    & ~w_clr[2]) | w_tx_drop;
    end
  end

  // TX FSM: each state lasts r_tx_div+1 clocks; divisor latched at every start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_state <= TX_IDLE;
      r_tx       <= 1'b1;
      r_tx_cnt   <= 16'd0;
      r_tx_div   <= 16'd0;
      r_tx_shift <= 8'd0;
      r_tx_bit   <= 3'd0;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (!w_tx_empty) begin
            r_tx_state <= TX_START;
            r_tx       <= 1'b0;
            r_tx_cnt   <= r_div;
            r_tx_div   <= r_div;
            r_tx_shift <= w_tx_head;
          end
        end
        TX_START: begin
          if (r_tx_cnt == 16'd0) begin
            r_tx_state <= TX_DATA;
            r_tx       <= r_tx_shift[0];
            r_tx_cnt   <= r_tx_div;
            r_tx_bit   <= 3'd0;
          end else begin
            r_tx_cnt <= r_tx_cnt - 16'd1;
          end
        end
        TX_DATA: begin
          if (r_tx_cnt == 16'd0) begin
            r_tx_cnt <= r_tx_div;
            if (r_tx_bit == 3'd7) begin
              r_tx_state <= TX_STOP;
              r_tx       <= 1'b1;
            end else begin
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
              r_tx       <= r_tx_shift[1];
              r_tx_bit   <= r_tx_bit + 3'd1;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt - 16'd1;
          end
        end
        default: begin
          if (r_tx_cnt == 16'd0) begin
            if (!w_tx_empty) begin
              r_tx_state <= TX_START;
              r_tx       <= 1'b0;
              r_tx_cnt   <= r_div;
              r_tx_div   <= r_div;
              r_tx_shift <= w_tx_head;
            end else begin
              r_tx_state <= TX_IDLE;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt - 16'd1;
          end
        end
      endcase
    end
  end

  // RX synchronizer (s1, s2) plus one history flop for falling-edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_s3 <= 1'b1;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
    end
  end

  // RX FSM: half-period to mid-start, then full periods to each bit centre.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= 16'd0;
      r_rx_div   <= 16'd0;
      r_rx_shift <= 8'd0;
      r_rx_bit   <= 3'd0;
    end else begin
      case (r_rx_state)
        RX_IDLE: begin
          if (w_rx_fall) begin
            r_rx_state <= RX_START;
            r_rx_cnt   <= {1'b0, r_div[15:1]};
            r_rx_div   <= r_div;
          end
        end
        RX_START: begin
          if (r_rx_cnt == 16'd0) begin
            if (r_rx_s2) begin
              r_rx_state <= RX_IDLE;
            end else begin
              r_rx_state <= RX_DATA;
              r_rx_cnt   <= r_rx_div;
              r_rx_bit   <= 3'd0;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt - 16'd1;
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == 16'd0) begin
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            r_rx_cnt   <= r_rx_div;
            if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
            else                  r_rx_bit   <= r_rx_bit + 3'd1;
          end else begin
            r_rx_cnt <= r_rx_cnt - 16'd1;
          end
        end
        RX_STOP: begin
          if (r_rx_cnt == 16'd0) begin
            r_rx_state <= r_rx_s2 ? RX_IDLE : RX_WAIT;
          end else begin
            r_rx_cnt <= r_rx_cnt - 16'd1;
          end
        end
        default: begin
          if (r_rx_s2) r_rx_state <= RX_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_soc_uart.sv
// Bench for soc_uart: register vector table, hand-written serial sequences and
// randomized RX / loopback traffic checked against a queue-based byte model.
module tb_soc_uart;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  addr;
  logic        rw;
  logic [31:0] dwrite;
  logic [31:0] dread;
  logic        valid;
  logic        ready;
  logic        rx;
  logic        tx;
  logic        loop_en;
  logic        rx_drv;

  int checks = 0;
  int errors = 0;

  assign rx = loop_en ? tx : rx_drv;

  always #5 clk = ~clk;

  soc_uart #(.DEFAULT_DIV(103), .FIFO_DEPTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .addr    (addr),
    .rw      (rw),
    .dwrite  (dwrite),
    .dread   (dread),
    .valid   (valid),
    .ready   (ready),
    .rx      (rx),
    .tx      (tx)
  );

  typedef struct {
    logic [3:0]  a;
    logic        w;
    logic [31:0] d;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // One bus access, entered and left at a negedge; also checks the one-cycle strobe.
  task automatic bus(input logic [3:0] a, input logic w, input logic [31:0] d, output logic [31:0] q);
    logic r_resp;
    addr = a; rw = w; dwrite = d; valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0; rw = 1'b0; dwrite = 32'd0; addr = 4'd0;
    r_resp = ready;
    q = dread;
    @(negedge clk);
    check("handshake", {29'd0, r_resp, ready, (dread != 32'd0)}, 32'h4);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] q;
    bus(a, 1'b1, d, q);
  endtask

  task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] q;
    bus(a, 1'b0, 32'd0, q);
    check(name, q, exp);
  endtask

  // Compare tx at every negedge against the ideal 8N1 waveform plus one idle sample.
  task automatic check_frame(input logic [7:0] b, input int div);
    logic [9:0] bits;
    logic       e;
    int         bad;
    int         first;
    bits  = {1'b1, b, 1'b0};
    bad   = 0;
    first = -1;
    for (int s = 0; s <= 10 * (div + 1); s++) begin
      e = (s == 10 * (div + 1)) ? 1'b1 : bits[s / (div + 1)];
      if (tx !== e) begin
        bad++;
        if (first < 0) first = s;
      end
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL tx_frame 0x%02h: %0d wrong samples (first at %0d), required 0", b, bad, first);
    end
  endtask

  // Drive one serial frame on rx, bit length in clocks; line left idle high.
  task automatic send_rx(input logic [7:0] b, input logic stop, input int bitlen);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx_drv = bits[k];
      repeat (bitlen) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  vec_t        vecs[19];
  logic [7:0]  model_q[$];
  logic        model_ovr;
  logic [31:0] q;
  logic [7:0]  b;
  int          div;
  int          n;

  initial begin
    reset_n = 1'b0; valid = 1'b0; rw = 1'b0; addr = 4'd0; dwrite = 32'd0;
    rx_drv = 1'b1; loop_en = 1'b0;

    vecs[0]  = '{4'h4, 1'b0, 32'h0,          1'b1, 32'h0000_0006};
    vecs[1]  = '{4'h8, 1'b0, 32'h0,          1'b1, 32'd103};
    vecs[2]  = '{4'hC, 1'b0, 32'h0,          1'b1, 32'h0};
    vecs[3]  = '{4'h0, 1'b0, 32'h0,          1'b1, 32'h0};
    vecs[4]  = '{4'h5, 1'b0, 32'h0,          1'b1, 32'h0000_0006};
    vecs[5]  = '{4'h8, 1'b1, 32'h0,          1'b0, 32'h0};
    vecs[6]  = '{4'h8, 1'b0, 32'h0,          1'b1, 32'd3};
    vecs[7]  = '{4'h8, 1'b1, 32'h2,          1'b0, 32'h0};
    vecs[8]  = '{4'h8, 1'b0, 32'h0,          1'b1, 32'd3};
    vecs[9]  = '{4'h8, 1'b1, 32'h0001_2345,  1'b0, 32'h0};
    vecs[10] = '{4'h8, 1'b0, 32'h0,          1'b1, 32'h0000_2345};
    vecs[11] = '{4'hC, 1'b1, 32'hFFFF_FFFF,  1'b0, 32'h0};
    vecs[12] = '{4'hC, 1'b0, 32'h0,          1'b1, 32'h0};
    vecs[13] = '{4'h4, 1'b1, 32'hFFFF_FFFF,  1'b0, 32'h0};
    vecs[14] = '{4'h4, 1'b0, 32'h0,          1'b1, 32'h0000_0006};
    vecs[15] = '{4'h8, 1'b1, 32'h4,          1'b0, 32'h0};
    vecs[16] = '{4'h8, 1'b0, 32'h0,          1'b1, 32'd4};
    vecs[17] = '{4'h8, 1'b1, 32'd103,        1'b0, 32'h0};
    vecs[18] = '{4'h8, 1'b0, 32'h0,          1'b1, 32'd103};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_dread", dread, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Register map vectors
    for (int i = 0; i < 19; i++) begin
      bus(vecs[i].a, vecs[i].w, vecs[i].d, q);
      if (vecs[i].chk) check($sformatf("vec%0d", i), q, vecs[i].exp);
    end

    // TX waveform at DIV=3, then busy flag while a frame is in flight
    wr(4'h8, 32'd3);
    wr(4'h0, 32'h55);
    check_frame(8'h55, 3);
    rd_chk("status_after_frame", 4'h4, 32'h0000_0006);
    wr(4'h0, 32'h00);
    rd_chk("status_busy", 4'h4, 32'h0000_0086);
    repeat (50) @(negedge clk);

    // Loopback two back-to-back frames
    loop_en = 1'b1;
    wr(4'h0, 32'hA3);
    wr(4'h0, 32'h0F);
    repeat (100) @(negedge clk);
    rd_chk("loop_rd0", 4'h0, 32'h0000_01A3);
    rd_chk("loop_rd1", 4'h0, 32'h0000_010F);
    rd_chk("loop_rd2", 4'h0, 32'h0);
    rd_chk("loop_status", 4'h4, 32'h0000_0006);
    loop_en = 1'b0;

    // TX FIFO fill and overflow at DIV=103; first byte (0x00) goes straight to the shifter
    wr(4'h8, 32'd103);
    for (int i = 0; i < 9; i++) wr(4'h0, 32'(i));
    rd_chk("tx_fill_status", 4'h4, 32'h0000_0085);
    wr(4'h0, 32'hAA);
    wr(4'h0, 32'hAA);
    rd_chk("tx_ovf_status", 4'h4, 32'h0000_00C5);
    wr(4'h4, 32'h40);
    rd_chk("tx_ovf_clear", 4'h4, 32'h0000_0085);

    // Reset in the middle of data bit 3 of the 0x00 frame
    repeat (440) @(negedge clk);
    check("midframe_tx_low", {31'd0, tx}, 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_tx", {31'd0, tx}, 32'd1);
    check("async_reset_ready", {31'd0, ready}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rd_chk("post_reset_status", 4'h4, 32'h0000_0006);
    rd_chk("post_reset_div", 4'h8, 32'd103);
    wr(4'h8, 32'd3);
    wr(4'h0, 32'hC4);
    check_frame(8'hC4, 3);

    // Framing error, then a one-clock glitch on idle rx
    send_rx(8'h5A, 1'b0, 4);
    repeat (10) @(negedge clk);
    rd_chk("frame_err_status", 4'h4, 32'h0000_0026);
    rd_chk("frame_err_data", 4'h0, 32'h0);
    wr(4'h4, 32'h20);
    rd_chk("frame_err_clear", 4'h4, 32'h0000_0006);
    rx_drv = 1'b0;
    @(negedge clk);
    rx_drv = 1'b1;
    repeat (20) @(negedge clk);
    rd_chk("glitch_status", 4'h4, 32'h0000_0006);
    rd_chk("glitch_data", 4'h0, 32'h0);

    // Random RX bursts: bytes beyond 8 are lost and flag rx_ovr
    for (int r = 0; r < 6; r++) begin
      div = int'($urandom_range(3, 6));
      n   = int'($urandom_range(1, 11));
      wr(4'h8, 32'(div));
      model_q.delete();
      model_ovr = 1'b0;
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        send_rx(b, 1'b1, div + 1);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        if (model_q.size() < 8) model_q.push_back(b);
        else model_ovr = 1'b1;
      end
      repeat (2 * (div + 1) + 4) @(negedge clk);
      rd_chk($sformatf("rnd_rx%0d_status", r), 4'h4,
             {27'd0, model_ovr, (model_q.size() == 8), (model_q.size() == 0), 2'b10});
      while (model_q.size() > 0) begin
        b = model_q.pop_front();
        rd_chk($sformatf("rnd_rx%0d_data", r), 4'h0, {23'd0, 1'b1, b});
      end
      rd_chk($sformatf("rnd_rx%0d_empty", r), 4'h0, 32'h0);
      wr(4'h4, 32'h10);
    end

    // Random loopback rounds exercising gapless STOP->START transmission
    loop_en = 1'b1;
    for (int r = 0; r < 4; r++) begin
      div = int'($urandom_range(3, 7));
      n   = int'($urandom_range(1, 8));
      wr(4'h8, 32'(div));
      model_q.delete();
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        wr(4'h0, {24'd0, b});
        model_q.push_back(b);
      end
      repeat ((n + 1) * 10 * (div + 1) + 20) @(negedge clk);
      while (model_q.size() > 0) begin
        b = model_q.pop_front();
        rd_chk($sformatf("rnd_loop%0d_data", r), 4'h0, {23'd0, 1'b1, b});
      end
      rd_chk($sformatf("rnd_loop%0d_status", r), 4'h4, 32'h0000_0006);
    end
    loop_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
